// File: rtl/pdh_iq_rotator_bank.sv
// pdh_iq_rotator_bank: NUM_CH-pair IQ phase rotator for the PDH loop.
// Shadow/active coefficient banks, GPIO command decoder, 3-stage datapath.
//
// Ports:
//   clk, rst_i      system clock, async active-high reset
//   cmd_i           async PS GPIO word: [30] strobe, [29:26] op, [25:0] data
//   adc_a_i/adc_b_i offset-binary samples, channel k at [k*ADC_W +: ADC_W]
//   adc_valid_i     qualifies both ADC buses
//   i_o/q_o         rotated, saturated I/Q, channel k at [k*OUT_W +: OUT_W]
//   out_valid_o     adc_valid_i delayed by 3
//   readback_o      {2'b0, op, err, ch, sel, 3'b0, value[15:0]}
//   cmd_ack_o       toggles once per executed command
module pdh_iq_rotator_bank #(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 14,
  parameter int COEF_W     = 16,
  parameter int OUT_W      = 16,
  parameter int ADC_INVERT = 1
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic [31:0]             cmd_i,
  input  logic [NUM_CH*ADC_W-1:0] adc_a_i,
  input  logic [NUM_CH*ADC_W-1:0] adc_b_i,
  input  logic                    adc_valid_i,
  output logic [NUM_CH*OUT_W-1:0] i_o,
  output logic [NUM_CH*OUT_W-1:0] q_o,
  output logic                    out_valid_o,
  output logic [31:0]             readback_o,
  output logic                    cmd_ack_o
);

  localparam int SW = ADC_W + 1;
  localparam int PW = SW + COEF_W;
  localparam int FW = ADC_W + COEF_W + 2;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [COEF_W-1:0] C_ONE =
    {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MID =
    {2'b01, {(ADC_W-1){1'b0}}};
  localparam logic signed [FW-1:0] O_MAX =
    {{(FW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [FW-1:0] O_MIN =
    {{(FW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  function automatic logic signed [SW-1:0] to_s(
    input logic [ADC_W-1:0] raw
  );
    logic signed [SW-1:0] r;
    r = signed'({1'b0, raw});
    if (ADC_INVERT != 0) return S_MID - r;
    else return r - S_MID;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(
    input logic signed [FW-1:0] x
  );
    if (x > O_MAX) return O_MAX[OUT_W-1:0];
    else if (x < O_MIN) return O_MIN[OUT_W-1:0];
    else return x[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] fin(
    input logic signed [PW-1:0] x,
    input logic signed [PW-1:0] y,
    input logic                 sub
  );
    logic signed [FW-1:0] t;
    if (sub) t = FW'(x) - FW'(y);
    else t = FW'(x) + FW'(y);
    t = t >>> (COEF_W - 1);
    return sat(t);
  endfunction

  function automatic logic [15:0] to16(
    input logic signed [COEF_W-1:0] c
  );
    logic signed [31:0] w;
    w = 32'(c);
    return w[15:0];
  endfunction

  // ---------------- command synchroniser ----------------
  logic [31:0] sync1;
  logic [31:0] sync2;
  logic [31:0] sync3;
  logic [1:0]  fill;
  logic        arm;
  logic        strb_d;
  logic        cmd_edge;

  // arm only after the strobe is seen low with real data in sync3,
  // so a strobe held through reset release never fires.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      fill   <= '0;
      arm    <= 1'b0;
      strb_d <= 1'b0;
    end else begin
      sync1  <= cmd_i;
      sync2  <= sync1;
      sync3  <= sync2;
      strb_d <= sync3[30];
      if (fill != 2'd3) fill <= fill + 2'd1;
      if (fill == 2'd3 && !sync3[30]) arm <= 1'b1;
    end
  end

  assign cmd_edge = arm & sync3[30] & ~strb_d;

  // ---------------- decoder / coefficient banks ----------------
  state_t      state;
  logic [29:0] cmd_q;

  logic signed [COEF_W-1:0] shadow_cos [NUM_CH];
  logic signed [COEF_W-1:0] shadow_sin [NUM_CH];
  logic signed [COEF_W-1:0] active_cos [NUM_CH];
  logic signed [COEF_W-1:0] active_sin [NUM_CH];

  logic [3:0]               op;
  logic [25:0]              data;
  logic [3:0]               ch;
  logic [CW-1:0]            idx;
  logic [1:0]               sel;
  logic signed [COEF_W-1:0] val;
  logic                     ch_ok;
  logic                     is_nop;
  logic                     is_cos;
  logic                     is_sin;
  logic                     is_commit;
  logic                     is_read;
  logic signed [COEF_W-1:0] rd_coef;
  logic                     rb_err;
  logic [3:0]               rb_ch;
  logic [1:0]               rb_sel;
  logic [15:0]              rb_val;
  logic [31:0]              rb_next;
  logic                     unused_cmd;

  assign op        = cmd_q[29:26];
  assign data      = cmd_q[25:0];
  assign ch        = data[25:22];
  assign idx       = ch[CW-1:0];
  assign sel       = data[1:0];
  assign val       = data[COEF_W-1:0];
  assign ch_ok     = {1'b0, ch} < 5'(NUM_CH);
  assign is_nop    = (op == 4'd0);
  assign is_cos    = (op == 4'd1);
  assign is_sin    = (op == 4'd2);
  assign is_commit = (op == 4'd3);
  assign is_read   = (op == 4'd4);
  assign unused_cmd = ^{sync3[31], cmd_q};

  always_comb begin
    rd_coef = '0;
    unique case (sel)
      2'd0: rd_coef = shadow_cos[idx];
      2'd1: rd_coef = shadow_sin[idx];
      2'd2: rd_coef = active_cos[idx];
      2'd3: rd_coef = active_sin[idx];
    endcase
  end

  always_comb begin
    rb_err = 1'b0;
    rb_ch  = '0;
    rb_sel = '0;
    rb_val = '0;
    unique case (1'b1)
      is_nop: ;
      is_cos, is_sin: begin
        rb_ch = ch;
        if (ch_ok) rb_val = to16(val);
        else rb_err = 1'b1;
      end
      is_commit: ;
      is_read: begin
        rb_ch  = ch;
        rb_sel = sel;
        if (ch_ok) rb_val = to16(rd_coef);
        else rb_err = 1'b1;
      end
      default: rb_err = 1'b1;
    endcase
    rb_next = {2'b00, op, rb_err, rb_ch,
               rb_sel, 3'b000, rb_val};
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cmd_q      <= '0;
      readback_o <= '0;
      cmd_ack_o  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_cos[k] <= C_ONE;
        shadow_sin[k] <= '0;
        active_cos[k] <= C_ONE;
        active_sin[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_edge) begin
            cmd_q <= sync3[29:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_cos && ch_ok) shadow_cos[idx] <= val;
          if (is_sin && ch_ok) shadow_sin[idx] <= val;
          if (is_commit) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (data[k]) begin
                active_cos[k] <= shadow_cos[k];
                active_sin[k] <= shadow_sin[k];
              end
            end
          end
          readback_o <= rb_next;
          cmd_ack_o  <= ~cmd_ack_o;
          // back-to-back edge: stay in EXEC with the new word
          if (cmd_edge) cmd_q <= sync3[29:0];
          else state <= IDLE;
        end
      endcase
    end
  end

  // ---------------- datapath ----------------
  logic                 v1;
  logic                 v2;
  logic signed [SW-1:0] s_a  [NUM_CH];
  logic signed [SW-1:0] s_b  [NUM_CH];
  logic signed [PW-1:0] p_ca [NUM_CH];
  logic signed [PW-1:0] p_sa [NUM_CH];
  logic signed [PW-1:0] p_cb [NUM_CH];
  logic signed [PW-1:0] p_sb [NUM_CH];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        s_a[k] <= '0;
        s_b[k] <= '0;
      end
    end else begin
      v1 <= adc_valid_i;
      if (adc_valid_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
          s_a[k] <= to_s(adc_a_i[k*ADC_W +: ADC_W]);
          s_b[k] <= to_s(adc_b_i[k*ADC_W +: ADC_W]);
        end
      end
    end
  end

  // all four products of a sample take the active bank at one edge
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      v2 <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        p_ca[k] <= '0;
        p_sa[k] <= '0;
        p_cb[k] <= '0;
        p_sb[k] <= '0;
      end
    end else begin
      v2 <= v1;
      if (v1) begin
        for (int k = 0; k < NUM_CH; k++) begin
          p_ca[k] <= PW'(s_a[k]) * PW'(active_cos[k]);
          p_sa[k] <= PW'(s_a[k]) * PW'(active_sin[k]);
          p_cb[k] <= PW'(s_b[k]) * PW'(active_cos[k]);
          p_sb[k] <= PW'(s_b[k]) * PW'(active_sin[k]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      i_o         <= '0;
      q_o         <= '0;
    end else begin
      out_valid_o <= v2;
      if (v2) begin
        for (int k = 0; k < NUM_CH; k++) begin
          i_o[k*OUT_W +: OUT_W] <= fin(p_ca[k], p_sb[k], 1'b1);
          q_o[k*OUT_W +: OUT_W] <= fin(p_sa[k], p_cb[k], 1'b0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pdh_iq_rotator_bank.sv
// tb_pdh_iq_rotator_bank: directed bench for pdh_iq_rotator_bank.
// Second instance with OUT_W=14 covers output saturation.
module tb_pdh_iq_rotator_bank;

  localparam int NC = 2;
  localparam int AW = 14;
  localparam int OW = 16;
  localparam int SOW = 14;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [31:0]    cmd_i;
  logic [NC*AW-1:0] adc_a;
  logic [NC*AW-1:0] adc_b;
  logic           adc_valid;
  logic [NC*OW-1:0] i_o;
  logic [NC*OW-1:0] q_o;
  logic           ov;
  logic [31:0]    rb;
  logic           ack;
  logic [NC*SOW-1:0] si_o;
  logic [NC*SOW-1:0] sq_o;
  logic           sov;
  logic [31:0]    srb;
  logic           sack;

  pdh_iq_rotator_bank #(
    .NUM_CH(NC), .ADC_W(AW), .COEF_W(16),
    .OUT_W(OW), .ADC_INVERT(1)
  ) dut (
    .clk(clk), .rst_i(rst_i), .cmd_i(cmd_i),
    .adc_a_i(adc_a), .adc_b_i(adc_b),
    .adc_valid_i(adc_valid),
    .i_o(i_o), .q_o(q_o), .out_valid_o(ov),
    .readback_o(rb), .cmd_ack_o(ack)
  );

  pdh_iq_rotator_bank #(
    .NUM_CH(NC), .ADC_W(AW), .COEF_W(16),
    .OUT_W(SOW), .ADC_INVERT(1)
  ) u_sat (
    .clk(clk), .rst_i(rst_i), .cmd_i(cmd_i),
    .adc_a_i(adc_a), .adc_b_i(adc_b),
    .adc_valid_i(adc_valid),
    .i_o(si_o), .q_o(sq_o), .out_valid_o(sov),
    .readback_o(srb), .cmd_ack_o(sack)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic ack_exp = 1'b0;

  typedef struct {
    logic [13:0] a0, b0, a1, b1;
    int          ei0, eq0, ei1, eq1;
  } vec_t;

  vec_t tv [4];

  int q_a0[$], q_b0[$], q_a1[$], q_b1[$];
  bit seen_new = 1'b0;

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int i_of(int k);
    return int'($signed(i_o[k*OW +: OW]));
  endfunction
  function automatic int q_of(int k);
    return int'($signed(q_o[k*OW +: OW]));
  endfunction

  function automatic int s_of(int raw);
    return 8192 - raw;
  endfunction

  // golden rotation: floor shift by 15, clamp to ow bits
  function automatic int rot(int sa, int sb, int c, int s,
                             bit isq, int ow);
    longint t;
    longint mx;
    if (isq) t = longint'(s) * sa + longint'(c) * sb;
    else t = longint'(c) * sa - longint'(s) * sb;
    t = t >>> 15;
    mx = (longint'(1) << (ow - 1)) - 1;
    if (t > mx) t = mx;
    if (t < -mx - 1) t = -mx - 1;
    return int'(t);
  endfunction

  function automatic logic [31:0] rbw(
    input logic [3:0] op, input logic err,
    input logic [3:0] ch, input logic [1:0] sel,
    input logic [15:0] v);
    return {2'b00, op, err, ch, sel, 3'b000, v};
  endfunction

  task automatic wait_ack(input string nm);
    int n;
    n = 0;
    while (ack !== ack_exp && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ack"}, ack, ack_exp);
  endtask

  task automatic send_cmd(input logic [3:0] op,
                          input logic [25:0] d);
    @(negedge clk);
    cmd_i = {1'b0, 1'b1, op, d};
    ack_exp = ~ack_exp;
    wait_ack("cmd");
    @(negedge clk);
    cmd_i[30] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [25:0] cd(int ch, int v);
    logic [25:0] d;
    d = 26'(v);
    d[25:22] = 4'(ch);
    return d;
  endfunction

  task automatic pulse_chk(input string nm,
    input logic [13:0] a0, input logic [13:0] b0,
    input logic [13:0] a1, input logic [13:0] b1,
    input int ei0, input int eq0,
    input int ei1, input int eq1);
    @(negedge clk);
    adc_a = {a1, a0};
    adc_b = {b1, b0};
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, ov, 0);
    @(negedge clk);
    chk({nm, "_valid"}, ov, 1);
    chk({nm, "_i0"}, i_of(0), ei0);
    chk({nm, "_q0"}, q_of(0), eq0);
    chk({nm, "_i1"}, i_of(1), ei1);
    chk({nm, "_q1"}, q_of(1), eq1);
  endtask

  task automatic stream_check();
    int a0, b0, a1, b1, oi, oq, ni, nq;
    bit mo, mn;
    if (q_a0.size() == 0) begin
      chk("stream_extra_valid", ov, 0);
      return;
    end
    a0 = q_a0.pop_front();
    b0 = q_b0.pop_front();
    a1 = q_a1.pop_front();
    b1 = q_b1.pop_front();
    oi = rot(s_of(a0), s_of(b0), 32767, -32768, 0, 16);
    oq = rot(s_of(a0), s_of(b0), 32767, -32768, 1, 16);
    ni = rot(s_of(a0), s_of(b0), 16384, -16384, 0, 16);
    nq = rot(s_of(a0), s_of(b0), 16384, -16384, 1, 16);
    mo = (i_of(0) == oi) && (q_of(0) == oq);
    mn = (i_of(0) == ni) && (q_of(0) == nq);
    checks++;
    if (!(mn || (mo && !seen_new))) begin
      errors++;
      $display("FAIL stream_ch0: got %0d/%0d old %0d/%0d new %0d/%0d",
               i_of(0), q_of(0), oi, oq, ni, nq);
    end
    if (mn && !mo) seen_new = 1'b1;
    chk("stream_i1", i_of(1),
        rot(s_of(a1), s_of(b1), 23170, 23170, 0, 16));
    chk("stream_q1", q_of(1),
        rot(s_of(a1), s_of(b1), 23170, 23170, 1, 16));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic prev;
    tv[0] = '{14'd0, 14'd8192, 14'd16383, 14'd8192,
              8191, 0, -8191, 0};
    tv[1] = '{14'd8192, 14'd0, 14'd4096, 14'd12288,
              0, 8191, 4095, -4096};
    tv[2] = '{14'd8191, 14'd8193, 14'd16383, 14'd0,
              0, -1, -8191, 8191};
    tv[3] = '{14'd100, 14'd16000, 14'd8192, 14'd8192,
              8091, -7808, 0, 0};

    rst_i = 1'b1;
    cmd_i = '0;
    adc_a = '0;
    adc_b = '0;
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_i_o", i_o, 0);
    chk("rst_q_o", q_o, 0);
    chk("rst_valid", ov, 0);
    chk("rst_readback", rb, 0);
    chk("rst_ack", ack, 0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++)
      pulse_chk($sformatf("vec%0d", v),
                tv[v].a0, tv[v].b0, tv[v].a1, tv[v].b1,
                tv[v].ei0, tv[v].eq0, tv[v].ei1, tv[v].eq1);
    repeat (2) @(negedge clk);
    chk("hold_valid", ov, 0);
    chk("hold_i0", i_of(0), tv[3].ei0);

    send_cmd(4'd2, cd(1, 16'h5A82));
    chk("set_sin_err", rb[25], 0);
    send_cmd(4'd1, cd(1, 16'h5A82));
    send_cmd(4'd4, cd(1, 2));
    chk("rd_act_pre", rb, rbw(4, 0, 1, 2, 16'h7FFF));
    send_cmd(4'd4, cd(1, 0));
    chk("rd_shadow_cos", rb, rbw(4, 0, 1, 0, 16'h5A82));
    send_cmd(4'd3, 26'b10);
    send_cmd(4'd4, cd(1, 2));
    chk("rd_act_cos1", rb, rbw(4, 0, 1, 2, 16'h5A82));
    send_cmd(4'd4, cd(1, 3));
    chk("rd_act_sin1", rb, rbw(4, 0, 1, 3, 16'h5A82));
    send_cmd(4'd4, cd(0, 2));
    chk("rd_act_cos0", rb, rbw(4, 0, 0, 2, 16'h7FFF));

    pulse_chk("rot", 14'd8192, 14'd0, 14'd0, 14'd8192,
              0, 8191, 5792, 5792);

    send_cmd(4'd1, cd(5, 16'h1234));
    chk("bad_ch_rb", rb, rbw(1, 1, 5, 0, 16'h0000));
    send_cmd(4'd4, cd(1, 0));
    chk("bad_ch_nowrite", rb, rbw(4, 0, 1, 0, 16'h5A82));
    send_cmd(4'd4, cd(6, 1));
    chk("bad_ch_read", rb, rbw(4, 1, 6, 1, 16'h0000));
    send_cmd(4'd9, cd(1, 16'h00FF));
    chk("bad_op", rb, rbw(9, 1, 0, 0, 16'h0000));
    send_cmd(4'd0, cd(3, 5));
    chk("nop", rb, 0);

    send_cmd(4'd2, cd(0, 16'h8000));
    send_cmd(4'd3, 26'b01);
    pulse_chk("satmain", 14'd0, 14'd0, 14'd8192, 14'd8192,
              16383, -1, 0, 0);
    chk("sat_i0", int'($signed(si_o[SOW-1:0])), 8191);
    chk("sat_q0", int'($signed(sq_o[SOW-1:0])), -1);

    @(negedge clk);
    cmd_i = {1'b0, 1'b1, 4'd0, 26'd0};
    cnt = 0;
    prev = ack;
    repeat (20) begin
      @(negedge clk);
      if (ack !== prev) cnt++;
      prev = ack;
    end
    chk("held_once", cnt, 1);
    ack_exp = ~ack_exp;
    cmd_i[30] = 1'b0;
    repeat (6) @(negedge clk);
    cmd_i[30] = 1'b1;
    ack_exp = ~ack_exp;
    wait_ack("retoggle");
    @(negedge clk);
    cmd_i[30] = 1'b0;
    repeat (5) @(negedge clk);

    send_cmd(4'd1, cd(0, 16'h4000));
    send_cmd(4'd2, cd(0, 16'hC000));
    fork
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (ov) stream_check();
          if (c < 44) begin
            int r0, r1, r2, r3;
            r0 = $urandom_range(0, 16383);
            r1 = $urandom_range(0, 16383);
            r2 = $urandom_range(0, 16383);
            r3 = $urandom_range(0, 16383);
            adc_a = {14'(r2), 14'(r0)};
            adc_b = {14'(r3), 14'(r1)};
            adc_valid = 1'b1;
            q_a0.push_back(r0);
            q_b0.push_back(r1);
            q_a1.push_back(r2);
            q_b1.push_back(r3);
          end else begin
            adc_valid = 1'b0;
          end
        end
      end
      begin
        repeat (12) @(negedge clk);
        send_cmd(4'd3, 26'b01);
      end
    join
    chk("stream_new_seen", seen_new, 1);
    chk("stream_drained", q_a0.size(), 0);
    send_cmd(4'd4, cd(0, 2));
    chk("rd_stream_cos0", rb, rbw(4, 0, 0, 2, 16'h4000));

    adc_a = {14'd8192, 14'd0};
    adc_b = {14'd8192, 14'd8192};
    adc_valid = 1'b1;
    repeat (5) @(negedge clk);
    cmd_i = {1'b0, 1'b1, 4'd1, cd(0, 16'h1111)};
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("mrst_i_o", i_o, 0);
    chk("mrst_q_o", q_o, 0);
    chk("mrst_valid", ov, 0);
    chk("mrst_rb", rb, 0);
    chk("mrst_ack", ack, 0);
    @(negedge clk);
    rst_i = 1'b0;
    ack_exp = 1'b0;
    repeat (20) @(negedge clk);
    chk("mrst_no_exec", ack, 0);
    chk("mrst_coef_i0", i_of(0), 8191);
    cmd_i[30] = 1'b0;
    adc_valid = 1'b0;
    repeat (6) @(negedge clk);
    send_cmd(4'd4, cd(0, 0));
    chk("mrst_rd_cos", rb, rbw(4, 0, 0, 0, 16'h7FFF));
    send_cmd(4'd4, cd(0, 3));
    chk("mrst_rd_sin", rb, rbw(4, 0, 0, 3, 16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
